// File: rtl/melody_sequencer_if.sv
// Control, song-ROM and board-output bundle for melody_sequencer.
// The sequencer uses the slave modport; the mode controller and the board side use master.
interface melody_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              step_mode;
  logic              advance;
  logic              loop_en;
  logic [1:0]        tempo_sel;
  logic [ADDR_W-1:0] song_base;
  logic [ADDR_W-1:0] song_len;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              pwm;
  logic [6:0]        lights;
  logic              is_high;
  logic              is_low;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_index;

  modport slave (
    input  start, stop, pause, step_mode, advance, loop_en, tempo_sel,
           song_base, song_len, rom_data,
    output rom_addr, pwm, lights, is_high, is_low, busy, done, cur_index
  );

  modport master (
    output start, stop, pause, step_mode, advance, loop_en, tempo_sel,
           song_base, song_len, rom_data,
    input  rom_addr, pwm, lights, is_high, is_low, busy, done, cur_index
  );
endinterface

// File: rtl/melody_sequencer.sv
// Plays a note sequence from an external synchronous ROM onto the buzzer PWM and note lights,
// with tempo scaling, pause/stop, looping and a step (learning) mode.
module melody_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int CNT_W       = 32,
  parameter int MID_HP_OVR  = 0
) (
  input logic               clk,
  input logic               rst_n,
  melody_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, GAP, TONE, HOLD} state_e;

  localparam logic [CNT_W-1:0] UNIT = CNT_W'(UNIT_CYCLES);
  localparam logic [CNT_W-1:0] GAPC = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        note_q, note_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic              pwm_q, pwm_d;
  logic [6:0]        lights_q, lights_d;
  logic              hi_q, hi_d;
  logic              lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]        oct;
  logic [3:0]        deg;
  logic              rest;
  logic [CNT_W-1:0]  slot_len, gap_len, tone_len;
  logic [CNT_W-1:0]  mid_hp, hp;
  logic [6:0]        note_light;
  logic [ADDR_W:0]   nxt_idx;
  logic              adv;

  function automatic logic [CNT_W-1:0] mid_table(input logic [3:0] d);
    logic [CNT_W-1:0] r;
    case (d)
      4'd1:    r = CNT_W'(95602);
      4'd2:    r = CNT_W'(85179);
      4'd3:    r = CNT_W'(75873);
      4'd4:    r = CNT_W'(71633);
      4'd5:    r = CNT_W'(63776);
      4'd6:    r = CNT_W'(56818);
      4'd7:    r = CNT_W'(50607);
      default: r = '0;
    endcase
    if (MID_HP_OVR != 0) r = CNT_W'(MID_HP_OVR);
    return r;
  endfunction

  assign oct        = note_q[5:4];
  assign deg        = note_q[3:0];
  assign rest       = (oct == 2'b00) || (deg == 4'd0) || (deg > 4'd7);
  assign note_light = rest ? 7'd0 : (7'h40 >> (deg - 4'd1));
  assign nxt_idx    = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign mid_hp     = mid_table(deg);

  always_comb begin
    slot_len = UNIT << note_q[7:6];
    gap_len  = GAPC;
    case (bus.tempo_sel)
      2'b01: begin slot_len = slot_len >> 1; gap_len = gap_len >> 1; end
      2'b10: begin slot_len = slot_len << 1; gap_len = gap_len << 1; end
      default: ;
    endcase
    tone_len = slot_len - gap_len;
    case (oct)
      2'b01:   hp = mid_hp << 1;
      2'b11:   hp = mid_hp >> 1;
      default: hp = mid_hp;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    idx_d    = idx_q;
    note_d   = note_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    pwm_d    = pwm_q;
    lights_d = lights_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    adv      = 1'b0;
    if (bus.stop && busy_q) begin
      state_d  = IDLE;
      idx_d    = '0;
      cnt_d    = '0;
      tcnt_d   = '0;
      pwm_d    = 1'b0;
      lights_d = '0;
      hi_d     = 1'b0;
      lo_d     = 1'b0;
      busy_d   = 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.start && !bus.stop) begin
        if (bus.song_len != '0) begin
          base_d  = bus.song_base;
          len_d   = bus.song_len;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = FETCH;
        end else begin
          done_d = 1'b1;
        end
      end
    end else if (!bus.pause) begin
      case (state_q)
        FETCH: state_d = LATCH;
        LATCH: begin
          note_d  = bus.rom_data;
          cnt_d   = '0;
          state_d = GAP;
        end
        GAP: begin
          if (cnt_q == gap_len - ONE) begin
            cnt_d    = '0;
            tcnt_d   = '0;
            pwm_d    = 1'b0;
            lights_d = note_light;
            hi_d     = !rest && (oct == 2'b11);
            lo_d     = !rest && (oct == 2'b01);
            state_d  = TONE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        TONE: begin
          if (cnt_q == tone_len - ONE) begin
            cnt_d    = '0;
            pwm_d    = 1'b0;
            lights_d = '0;
            hi_d     = 1'b0;
            lo_d     = 1'b0;
            if (bus.step_mode) state_d = HOLD;
            else               adv     = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
            // Square wave: flip every hp cycles, starting low at TONE entry.
            if (!rest) begin
              if (tcnt_q == hp - ONE) begin
                pwm_d  = ~pwm_q;
                tcnt_d = '0;
              end else begin
                tcnt_d = tcnt_q + ONE;
              end
            end
          end
        end
        HOLD:    adv = bus.advance;
        default: state_d = IDLE;
      endcase
      if (adv) begin
        if (nxt_idx < {1'b0, len_q}) begin
          idx_d   = nxt_idx[ADDR_W-1:0];
          state_d = FETCH;
        end else begin
          done_d = 1'b1;
          idx_d  = '0;
          if (bus.loop_en) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      note_q   <= '0;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      pwm_q    <= 1'b0;
      lights_q <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      note_q   <= note_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      pwm_q    <= pwm_d;
      lights_q <= lights_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.rom_addr  = busy_q ? base_q + idx_q : '0;
  assign bus.pwm       = pwm_q & ~bus.pause;
  assign bus.lights    = lights_q;
  assign bus.is_high   = hi_q;
  assign bus.is_low    = lo_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cur_index = idx_q;

endmodule
